// File: rtl/step_scheduler.sv
// step_scheduler: derives a one-cycle step strobe from CLOCK_50 with run / pause / single-step modes.
// Define STEP_DEBOUNCE_EN to insert a stability-window debouncer on each key after the synchroniser.
module step_scheduler #(
    parameter int MIN_SHIFT  = 20,
    parameter int RATE_W     = 3,
    parameter int CNT_W      = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_run_n,
    input  logic              key_pause_n,
    input  logic              key_step_n,
    input  logic [RATE_W-1:0] rate_sel,
    output logic              step_en,
    output logic [1:0]        mode,
    output logic [CNT_W-1:0]  step_count
);

    localparam int PRE_W   = MIN_SHIFT + (1 << RATE_W);
    localparam int K_PAUSE = 0;
    localparam int K_RUN   = 1;
    localparam int K_STEP  = 2;

    typedef enum logic [1:0] {
        MODE_PAUSE = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_STEP  = 2'b10
    } mode_t;

    logic [2:0]       keyRaw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       hist_q;
    logic [2:0]       keyLevel;
    logic [2:0]       press_d;
    logic [2:0]       press_q;
    mode_t            mode_q;
    mode_t            mode_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [PRE_W-1:0] terminal;
    logic             stepEn_q;
    logic             stepEn_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign keyRaw = {key_step_n, key_run_n, key_pause_n};

    // Press events are registered so every key sees the same fixed latency into the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            hist_q  <= '1;
            press_q <= '0;
        end else begin
            sync1_q <= keyRaw;
            sync2_q <= sync1_q;
            hist_q  <= keyLevel;
            press_q <= press_d;
        end
    end

    assign press_d = ~keyLevel & hist_q;

`ifdef STEP_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DEB_W-1:0] debCnt_q [3];
    logic [2:0]       debLevel_q;

    // The debounced level follows the synced level only after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            debLevel_q <= '1;
            for (int i = 0; i < 3; i++) begin
                debCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == debLevel_q[i]) begin
                    debCnt_q[i] <= '0;
                end else if (debCnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    debLevel_q[i] <= sync2_q[i];
                    debCnt_q[i]   <= '0;
                end else begin
                    debCnt_q[i] <= debCnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    assign keyLevel = debLevel_q;
`else
    assign keyLevel = sync2_q;

    // A zero-length stability window is meaningless; this empty block only exists when misconfigured.
    if (DEB_CYCLES < 1) begin : g_deb_cycles_invalid
    end
`endif

    assign terminal = (PRE_W'(1) << (MIN_SHIFT + int'(rate_sel))) - PRE_W'(1);

    always_comb begin
        mode_d   = mode_q;
        pre_d    = '0;
        stepEn_d = 1'b0;
        case (mode_q)
            MODE_PAUSE: begin
                if (press_q[K_PAUSE]) begin
                    mode_d = MODE_PAUSE;
                end else if (press_q[K_RUN]) begin
                    mode_d = MODE_RUN;
                end else if (press_q[K_STEP]) begin
                    mode_d = MODE_STEP;
                end
            end
            MODE_RUN: begin
                // ">=" keeps a lowered rate from wrapping the prescaler past its new terminal.
                if (pre_q >= terminal) begin
                    stepEn_d = 1'b1;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
                if (press_q[K_PAUSE]) begin
                    mode_d = MODE_PAUSE;
                    pre_d  = '0;
                end
            end
            MODE_STEP: begin
                stepEn_d = 1'b1;
                mode_d   = MODE_PAUSE;
            end
            default: begin
                mode_d = MODE_PAUSE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (stepEn_q) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= MODE_PAUSE;
            pre_q    <= '0;
            stepEn_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mode_q   <= mode_d;
            pre_q    <= pre_d;
            stepEn_q <= stepEn_d;
            count_q  <= count_d;
        end
    end

    assign step_en    = stepEn_q;
    assign mode       = mode_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: scoreboard bench for step_scheduler; expected pulse cycles are queued at stimulus time.
// Debounce scenario is compiled in only when STEP_DEBOUNCE_EN is defined.
module tb_step_scheduler;

    localparam int MIN_SHIFT  = 2;
    localparam int RATE_W     = 3;
    localparam int CNT_W      = 8;
    localparam int DEB_CYCLES = 16;

    logic              clk         = 1'b0;
    logic              reset       = 1'b1;
    logic              key_run_n   = 1'b1;
    logic              key_pause_n = 1'b1;
    logic              key_step_n  = 1'b1;
    logic [RATE_W-1:0] rate_sel    = '0;
    logic              step_en;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  step_count;

    int               cyc    = 0;
    int               checks = 0;
    int               passes = 0;
    int               expQ[$];
    logic [CNT_W-1:0] expCount = '0;

    step_scheduler #(
        .MIN_SHIFT (MIN_SHIFT),
        .RATE_W    (RATE_W),
        .CNT_W     (CNT_W),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_run_n  (key_run_n),
        .key_pause_n(key_pause_n),
        .key_step_n (key_step_n),
        .rate_sel   (rate_sel),
        .step_en    (step_en),
        .mode       (mode),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Every observed pulse must match the next queued cycle number and the modelled count.
    always @(negedge clk) begin
        int want;
        if (reset === 1'b1 && step_en === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_pulse: step_en=1 at cycle %0d, required no pulse", cyc);
            end else begin
                want = expQ.pop_front();
                if (cyc !== want) begin
                    $display("[TB] FAIL pulse_cycle: pulse at cycle %0d, required cycle %0d", cyc, want);
                end else begin
                    passes++;
                end
                checks++;
                if (step_count !== expCount) begin
                    $display("[TB] FAIL pulse_count: step_count=%0d, required %0d", step_count, expCount);
                end else begin
                    passes++;
                end
                expCount = expCount + CNT_W'(1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_queue_drained(input string name);
        checks++;
        if (expQ.size() != 0) begin
            $display("[TB] FAIL %s_missing: %0d pulses outstanding, required 0", name, expQ.size());
            expQ.delete();
        end else begin
            passes++;
        end
    endtask

    task automatic test_reset;
        int c;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({step_en, mode, step_count} !== '0) begin
            $display("[TB] FAIL reset_values: en=%0b mode=%0b count=%0d, required all zero", step_en, mode, step_count);
        end else begin
            passes++;
        end
        @(negedge clk);
        reset = 1'b1;
        c = cyc;
        waitUntil(c + 100);
        checks++;
        if (mode !== 2'b00 || step_en !== 1'b0 || step_count !== 8'd0) begin
            $display("[TB] FAIL idle_after_reset: en=%0b mode=%0b count=%0d, required 0/00/0", step_en, mode, step_count);
        end else begin
            passes++;
        end
    endtask

    task automatic test_single_step;
        int c;
        @(negedge clk);
        c = cyc;
        key_step_n = 1'b0;
        expQ.push_back(c + 5);
        waitUntil(c + 3);
        checks++;
        if (mode !== 2'b00) begin
            $display("[TB] FAIL step_early: mode=%0b at +3, required 00", mode);
        end else begin
            passes++;
        end
        waitUntil(c + 4);
        checks++;
        if (mode !== 2'b10) begin
            $display("[TB] FAIL step_mode: mode=%0b at +4, required 10", mode);
        end else begin
            passes++;
        end
        waitUntil(c + 5);
        checks++;
        if (mode !== 2'b00) begin
            $display("[TB] FAIL step_return: mode=%0b at +5, required 00", mode);
        end else begin
            passes++;
        end
        waitUntil(c + 10);
        key_step_n = 1'b1;
        waitUntil(c + 25);
        test_queue_drained("step");
        checks++;
        if (step_count !== 8'd1) begin
            $display("[TB] FAIL step_count: got %0d, required 1", step_count);
        end else begin
            passes++;
        end
    endtask

    task automatic test_run_pause;
        int c, e;
        @(negedge clk);
        rate_sel  = 3'd1;
        key_run_n = 1'b0;
        c = cyc;
        e = c + 4;
        for (int i = 1; i <= 5; i++) expQ.push_back(e + 8 * i);
        waitUntil(e - 1);
        checks++;
        if (mode !== 2'b00) begin
            $display("[TB] FAIL run_early: mode=%0b, required 00", mode);
        end else begin
            passes++;
        end
        waitUntil(e);
        checks++;
        if (mode !== 2'b01) begin
            $display("[TB] FAIL run_mode: mode=%0b, required 01", mode);
        end else begin
            passes++;
        end
        waitUntil(e + 40);
        key_run_n   = 1'b1;
        key_pause_n = 1'b0;
        waitUntil(e + 44);
        checks++;
        if (mode !== 2'b00) begin
            $display("[TB] FAIL run_pause_mode: mode=%0b, required 00", mode);
        end else begin
            passes++;
        end
        waitUntil(e + 46);
        key_pause_n = 1'b1;
        waitUntil(e + 70);
        test_queue_drained("run");
        checks++;
        if (step_count !== 8'd6) begin
            $display("[TB] FAIL run_count_hold: got %0d, required 6", step_count);
        end else begin
            passes++;
        end
    endtask

    task automatic test_rate_change;
        int c, e;
        @(negedge clk);
        rate_sel  = 3'd3;
        key_run_n = 1'b0;
        c = cyc;
        e = c + 4;
        expQ.push_back(e + 21);
        expQ.push_back(e + 25);
        expQ.push_back(e + 29);
        expQ.push_back(e + 33);
        expQ.push_back(e + 37);
        waitUntil(e + 10);
        key_run_n = 1'b1;
        waitUntil(e + 20);
        rate_sel = 3'd0;
        waitUntil(e + 33);
        key_pause_n = 1'b0;
        waitUntil(e + 36);
        checks++;
        if (mode !== 2'b01) begin
            $display("[TB] FAIL rate_still_run: mode=%0b, required 01", mode);
        end else begin
            passes++;
        end
        waitUntil(e + 37);
        checks++;
        if (mode !== 2'b00 || step_en !== 1'b1) begin
            $display("[TB] FAIL pause_on_terminal: mode=%0b en=%0b, required 00/1", mode, step_en);
        end else begin
            passes++;
        end
        waitUntil(e + 40);
        key_pause_n = 1'b1;
        waitUntil(e + 60);
        test_queue_drained("rate");
    endtask

    task automatic test_back_to_back;
        int c;
        @(negedge clk);
        key_run_n   = 1'b0;
        key_pause_n = 1'b0;
        c = cyc;
        waitUntil(c + 6);
        checks++;
        if (mode !== 2'b00) begin
            $display("[TB] FAIL run_pause_same_edge: mode=%0b, required 00", mode);
        end else begin
            passes++;
        end
        waitUntil(c + 8);
        key_run_n   = 1'b1;
        key_pause_n = 1'b1;
        waitUntil(c + 14);
        rate_sel   = 3'd3;
        key_run_n  = 1'b0;
        key_step_n = 1'b0;
        c = cyc;
        waitUntil(c + 4);
        checks++;
        if (mode !== 2'b01) begin
            $display("[TB] FAIL run_step_same_edge: mode=%0b, required 01", mode);
        end else begin
            passes++;
        end
        waitUntil(c + 8);
        checks++;
        if (mode !== 2'b01) begin
            $display("[TB] FAIL run_step_hold: mode=%0b, required 01", mode);
        end else begin
            passes++;
        end
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        waitUntil(c + 10);
        key_pause_n = 1'b0;
        waitUntil(c + 16);
        checks++;
        if (mode !== 2'b00) begin
            $display("[TB] FAIL run_step_pause: mode=%0b, required 00", mode);
        end else begin
            passes++;
        end
        key_pause_n = 1'b1;
        waitUntil(c + 50);
        test_queue_drained("back_to_back");
    endtask

    task automatic test_wrap_and_async_reset;
        int c, e;
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        expCount = '0;
        @(negedge clk);
        reset    = 1'b1;
        rate_sel = 3'd0;
        @(negedge clk);
        key_run_n = 1'b0;
        c = cyc;
        e = c + 4;
        for (int i = 1; i <= 257; i++) expQ.push_back(e + 4 * i);
        waitUntil(c + 6);
        key_run_n = 1'b1;
        waitUntil(e + 4 * 256 + 1);
        checks++;
        if (step_count !== 8'd0) begin
            $display("[TB] FAIL count_wrap: got %0d, required 0", step_count);
        end else begin
            passes++;
        end
        waitUntil(e + 4 * 258 - 1);
        @(posedge clk);
        #1;
        checks++;
        if (step_en !== 1'b1 || step_count !== 8'd1) begin
            $display("[TB] FAIL pre_reset_state: en=%0b count=%0d, required 1/1", step_en, step_count);
        end else begin
            passes++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (step_en !== 1'b0 || mode !== 2'b00 || step_count !== 8'd0) begin
            $display("[TB] FAIL async_reset: en=%0b mode=%0b count=%0d, required 0/00/0", step_en, mode, step_count);
        end else begin
            passes++;
        end
        expCount = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        c = cyc;
        waitUntil(c + 20);
        test_queue_drained("wrap");
        checks++;
        if (mode !== 2'b00 || step_count !== 8'd0) begin
            $display("[TB] FAIL after_reset_idle: mode=%0b count=%0d, required 00/0", mode, step_count);
        end else begin
            passes++;
        end
    endtask

`ifdef STEP_DEBOUNCE_EN
    task automatic test_debounce;
        int c;
        @(negedge clk);
        key_step_n = 1'b0;
        c = cyc;
        waitUntil(c + 5);
        key_step_n = 1'b1;
        waitUntil(c + 50);
        checks++;
        if (mode !== 2'b00 || step_count !== expCount) begin
            $display("[TB] FAIL glitch_press: mode=%0b count=%0d, required 00/%0d", mode, step_count, expCount);
        end else begin
            passes++;
        end
        key_step_n = 1'b0;
        c = cyc;
        expQ.push_back(c + DEB_CYCLES + 5);
        waitUntil(c + 20);
        key_step_n = 1'b1;
        waitUntil(c + 70);
        test_queue_drained("debounce");
    endtask
`endif

    initial begin
        test_reset();
        test_single_step();
        test_run_pause();
        test_rate_change();
        test_back_to_back();
        test_wrap_and_async_reset();
`ifdef STEP_DEBOUNCE_EN
        test_debounce();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/step_scheduler.md
Name: step_scheduler

Overview:
- Sequences the board-level state machine by generating a one-cycle step enable from the 50 MHz board clock, in place of clocking the FSM directly off a divided-clock bit.
- Offers three modes, driven by the active-low KEY pushbuttons: free-run at a switch-selected rate, pause, and single-step.
- Reports its mode and a running step count for display on LEDR/HEX.

Parameters:
MIN_SHIFT, 20, log2 of the shortest step period in clk cycles (rate_sel=0)
RATE_W, 3, width of rate_sel
CNT_W, 8, width of step_count
DEB_CYCLES, 16, debounce stability window in clk cycles (used only with STEP_DEBOUNCE_EN)

Ports:
clk  input  1  board clock (CLOCK_50)
reset  input  1  asynchronous, active-low reset; block is in reset while low
key_run_n  input  1  run button, active-low, asynchronous to clk
key_pause_n  input  1  pause button, active-low, asynchronous to clk
key_step_n  input  1  single-step button, active-low, asynchronous to clk
rate_sel  input  RATE_W  step period select; period = 2^(MIN_SHIFT+rate_sel) cycles
step_en  output  1  one-cycle step strobe to the sequenced FSM
mode  output  2  00=PAUSE, 01=RUN, 10=STEP; 11 never driven
step_count  output  CNT_W  number of step_en pulses issued, modulo 2^CNT_W

Behaviour:
- Reset (reset low, asynchronous): mode=PAUSE, step_en=0, step_count=0, prescaler=0, all key synchroniser and history flops=1 (unpressed).
- Key input path:
  - Each key passes through a 2-flop synchroniser, then a history flop.
  - A press is a falling edge: synced==0 and history==1. Exactly one press event per falling edge; holding a key produces no further events.
- Mode FSM, evaluated each clk edge using that cycle's press events:
  - PAUSE: pause press -> stay PAUSE. Else run press -> RUN. Else step press -> STEP.
  - RUN: pause press -> PAUSE. Run and step presses are ignored.
  - STEP: unconditionally -> PAUSE on the next edge. Any press during STEP is ignored.
  - Simultaneous presses: pause > run > step.
- Prescaler:
  - Width MIN_SHIFT+2^RATE_W bits. Counts only in RUN. Cleared to 0 on any entry to RUN and in PAUSE/STEP.
  - Terminal T = 2^(MIN_SHIFT+rate_sel) - 1, compared combinationally against the current rate_sel.
  - When prescaler >= T in RUN: a step fires and the prescaler clears to 0. Otherwise it increments.
  - The >= rule means a rate_sel decrease mid-count fires on the next cycle, never wraps.
- step_en (registered):
  - High for the single cycle after the edge on which a RUN terminal fires, or after the edge on which the FSM is in STEP.
  - First RUN pulse occurs exactly T+1 cycles after entering RUN, so the steady RUN period is T+1 cycles.
  - Pause press on the same edge as a RUN terminal: the step still fires; mode goes to PAUSE.
- step_count increments by 1 on every cycle step_en is high and wraps 2^CNT_W-1 -> 0.
- Latency, step key: key_step_n first sampled low at edge k -> mode=STEP after edge k+3 -> step_en high for the one cycle after edge k+4 -> mode=PAUSE after edge k+4.
- Reset asserted mid-operation: immediate return to reset values, including step_en dropping without completing its cycle. The count is lost.

Optional Feature:
STEP_DEBOUNCE_EN
- Defined: after the synchroniser, each key has a counter requiring the synced level to hold steady for DEB_CYCLES consecutive cycles before the debounced level (which feeds the history flop) changes. Glitches shorter than DEB_CYCLES produce no press. Press latency increases by DEB_CYCLES.
- Undefined: no debounce logic; the synced level feeds edge detection directly, with the latencies stated above.

Test Plan (MIN_SHIFT=2, CNT_W=8, macro undefined unless noted):
- Reset release, no keys, 100 cycles -> mode=00, step_en never high, step_count=0.
- key_step_n low at edge k, held 10 cycles -> exactly one step_en pulse, in the cycle after edge k+4; step_count=1; mode 00->10->00. Holding the key gives no second pulse.
- Run press, rate_sel=1 (T=7), 40 cycles -> step_en every 8 cycles, first 8 cycles after mode=01; step_count=5 at the end. Then pause press -> pulses stop, count holds.
- In RUN with rate_sel=3 and prescaler at 20 -> set rate_sel=0 (T=3) -> step_en the next cycle, then every 4 cycles.
- Run and pause pressed on the same edge from PAUSE -> mode stays 00. Run and step pressed together -> mode=01, no single-step pulse.
- 256 step pulses -> step_count wraps to 0. reset low mid-RUN -> all outputs zero asynchronously. With STEP_DEBOUNCE_EN, a 5-cycle key glitch yields no press; a 20-cycle press yields one step.
